// File: rtl/idu_hazard_ctrl.sv
// rtl/idu_hazard_ctrl.sv - decode-stage issue controller: register scoreboard, hazard stall, MDU sequencing
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  idu0 output holds a valid instruction
//   id_rs1/_addr, id_rs2/_addr  source register reads
//   id_rd/_addr               destination register write
//   id_mul, id_div            multi-cycle MDU op (both set is treated as div)
//   wb_valid, wb_rd_addr      register writeback from exu/MDU
//   exu_flush_req             taken branch/jump in exu, squashes decode
//   pipe_stall, pipe_flush    hold / clear the idu0 flop (combinational)
//   issue_valid               instruction leaves decode this cycle (combinational)
//   mdu_busy, mdu_done        MDU op in flight / one-cycle result pulse (registered)
//
// Build option: IDU_WB_BYPASS_EN forwards same-cycle writeback into the RAW check.

module idu_hazard_ctrl #(
    parameter int DIV_LAT = 34,
    parameter int MUL_LAT = 3,
    localparam int CNT_W  = $clog2(DIV_LAT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_rs1,
    input  logic [4:0] id_rs1_addr,
    input  logic       id_rs2,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rd,
    input  logic [4:0] id_rd_addr,
    input  logic       id_mul,
    input  logic       id_div,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd_addr,
    input  logic       exu_flush_req,
    output logic       pipe_stall,
    output logic       pipe_flush,
    output logic       issue_valid,
    output logic       mdu_busy,
    output logic       mdu_done
);

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // x0 has no storage bit, so it can never look pending.
    logic [31:1] pend_q, pend_d;
    logic [31:0] pend;
    assign pend = {pend_q, 1'b0};

    logic rs1_haz, rs2_haz, rd_haz, mdu_haz, hazard, mdu_op;

    assign mdu_op = id_mul | id_div;

`ifdef IDU_WB_BYPASS_EN
    // exu forwards the writeback value, so a source being written back this
    // cycle is already satisfied.
    assign rs1_haz = id_rs1 & pend[id_rs1_addr] & ~(wb_valid && (wb_rd_addr == id_rs1_addr));
    assign rs2_haz = id_rs2 & pend[id_rs2_addr] & ~(wb_valid && (wb_rd_addr == id_rs2_addr));
`else
    assign rs1_haz = id_rs1 & pend[id_rs1_addr];
    assign rs2_haz = id_rs2 & pend[id_rs2_addr];
`endif

    // WAW always uses the unmasked scoreboard.
    assign rd_haz  = id_rd & pend[id_rd_addr];
    assign mdu_haz = mdu_op & mdu_busy;
    assign hazard  = id_valid & (rs1_haz | rs2_haz | rd_haz | mdu_haz);

    // A flush squashes decode outright, so it overrides any stall.
    assign pipe_flush  = exu_flush_req;
    assign pipe_stall  = hazard & ~exu_flush_req;
    assign issue_valid = id_valid & ~hazard & ~exu_flush_req;

    assign mdu_busy = (state_q == MDU_BUSY);
    assign mdu_done = done_q;

    // Set after clear: a new producer issued in the writeback cycle of an
    // older one owns the register.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < 32; i++) begin
            if (wb_valid && (wb_rd_addr == 5'(i)))
                pend_d[i] = 1'b0;
            if (issue_valid && id_rd && (id_rd_addr == 5'(i)))
                pend_d[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (issue_valid && mdu_op) begin
                    state_d = MDU_BUSY;
                    cnt_d   = id_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                end
            end
            MDU_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

endmodule
